// File: rtl/refresco_lcd.sv
// Framebuffer-to-LCD refresh engine: scans the 1 KiB framebuffer page by page and
// streams command and data bytes to a page-addressed SPI LCD controller (SPI mode 0).
module refresco_lcd #(
    parameter int CLK_DIV = 2,
    parameter int PAGES   = 8,
    parameter int COLS    = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       rd,
    output logic [9:0] addr_rd,
    input  logic [7:0] din,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi,
    output logic       busy,
    output logic       done
);

    localparam int PW = (PAGES   > 1) ? $clog2(PAGES)   : 1;
    localparam int CW = (COLS    > 1) ? $clog2(COLS)    : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, CMD_LOAD, SHIFT, FETCH, WAIT, END} state_t;

    state_t          state, next_state;
    logic [PW-1:0]   page;
    logic [CW-1:0]   col;
    logic [1:0]      cmd_idx;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic [DW-1:0]   div_cnt;
    logic [7:0]      cmd_byte;
    logic            div_last, last_col, last_page, byte_end;

    assign div_last  = (int'(div_cnt) == CLK_DIV - 1);
    assign last_col  = (int'(col)  == COLS  - 1);
    assign last_page = (int'(page) == PAGES - 1);
    assign byte_end  = (state == SHIFT) && lcd_sclk && div_last && (bit_cnt == 3'd7);

    assign rd       = (state == FETCH);
    assign addr_rd  = 10'(int'(page) * COLS + int'(col));
    assign lcd_mosi = shreg[7];

    always_comb begin
        cmd_byte = 8'h00;
        case (cmd_idx)
            2'd0:    cmd_byte = 8'hB0 | 8'(page);
            2'd1:    cmd_byte = 8'h10;
            default: cmd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // lcd_dc doubles as "current byte is data" when choosing what follows a byte
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = CMD_LOAD;
            CMD_LOAD: next_state = SHIFT;
            SHIFT: begin
                if (byte_end) begin
                    if (!lcd_dc)        next_state = (cmd_idx == 2'd0) ? FETCH : CMD_LOAD;
                    else if (!last_col) next_state = FETCH;
                    else if (!last_page) next_state = CMD_LOAD;
                    else                next_state = END;
                end
            end
            FETCH:    next_state = WAIT;
            WAIT:     next_state = SHIFT;
            END:      next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page     <= '0;
            col      <= '0;
            cmd_idx  <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            lcd_sclk <= 1'b0;
            lcd_dc   <= 1'b0;
            lcd_cs_n <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lcd_cs_n <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CMD_LOAD: begin
                    shreg    <= cmd_byte;
                    lcd_dc   <= 1'b0;
                    cmd_idx  <= (cmd_idx == 2'd2) ? 2'd0 : cmd_idx + 2'd1;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    lcd_sclk <= 1'b0;
                end
                WAIT: begin
                    shreg    <= din;
                    lcd_dc   <= 1'b1;
                    bit_cnt  <= '0;
                    div_cnt  <= '0;
                    lcd_sclk <= 1'b0;
                end
                SHIFT: begin
                    if (!div_last) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!lcd_sclk) begin
                            lcd_sclk <= 1'b1;
                        end else begin
                            lcd_sclk <= 1'b0;
                            shreg    <= {shreg[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7 && lcd_dc) begin
                                if (last_col) begin
                                    col  <= '0;
                                    page <= last_page ? '0 : page + PW'(1);
                                end else begin
                                    col  <= col + CW'(1);
                                end
                            end
                        end
                    end
                end
                END: begin
                    lcd_cs_n <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_refresco_lcd.sv
// Directed bench for refresco_lcd: default geometry (full frame, timing, re-pulse,
// back-to-back, mid-frame reset) and a tiny CLK_DIV=1/PAGES=1/COLS=4 instance.
module tb_refresco_lcd;

    logic       clk = 1'b0;
    logic       rst, start_a, start_b;
    logic       rd_a, cs_a, dc_a, sclk_a, mosi_a, busy_a, done_a;
    logic       rd_b, cs_b, dc_b, sclk_b, mosi_b, busy_b, done_b;
    logic [9:0] addr_a, addr_b;
    logic [7:0] din_a = 8'h00, din_b = 8'h00;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    refresco_lcd #(.CLK_DIV(2), .PAGES(8), .COLS(128)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rd(rd_a), .addr_rd(addr_a), .din(din_a),
        .lcd_cs_n(cs_a), .lcd_dc(dc_a), .lcd_sclk(sclk_a), .lcd_mosi(mosi_a),
        .busy(busy_a), .done(done_a));

    refresco_lcd #(.CLK_DIV(1), .PAGES(1), .COLS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rd(rd_b), .addr_rd(addr_b), .din(din_b),
        .lcd_cs_n(cs_b), .lcd_dc(dc_b), .lcd_sclk(sclk_b), .lcd_mosi(mosi_b),
        .busy(busy_b), .done(done_b));

    function automatic logic [7:0] ram_byte(input logic [9:0] a);
        return a[7:0] ^ {6'b0, a[9:8]};
    endfunction

    always @(posedge clk) if (rd_a) din_a <= ram_byte(addr_a);
    always @(posedge clk) if (rd_b) din_b <= ram_byte(addr_b);

    // SPI decoders: sample at posedge+1, capture mosi on each sclk rise
    logic [7:0]  qa_byte[$], qb_byte[$];
    logic        qa_dc[$],   qb_dc[$];
    logic [9:0]  rd_addr_b[$];
    logic [7:0]  sh_a = 8'h00, sh_b = 8'h00;
    int unsigned bits_a = 0, bits_b = 0, rd_cnt_a = 0, viol_b = 0;
    logic        ps_a = 1'b0, ps_b = 1'b0, pm_b = 1'b0, pd_b = 1'b0;

    always @(posedge clk) begin
        #1;
        if (cs_a) bits_a = 0;
        else if (sclk_a && !ps_a) begin
            sh_a = {sh_a[6:0], mosi_a};
            bits_a++;
            if (bits_a == 8) begin qa_byte.push_back(sh_a); qa_dc.push_back(dc_a); bits_a = 0; end
        end
        if (rd_a) rd_cnt_a++;
        ps_a = sclk_a;
    end

    always @(posedge clk) begin
        #1;
        if (cs_b) bits_b = 0;
        else if (sclk_b && !ps_b) begin
            sh_b = {sh_b[6:0], mosi_b};
            bits_b++;
            if (bits_b == 8) begin qb_byte.push_back(sh_b); qb_dc.push_back(dc_b); bits_b = 0; end
        end
        if (sclk_b && (mosi_b !== pm_b || dc_b !== pd_b)) viol_b++;
        if (rd_b) rd_addr_b.push_back(addr_b);
        ps_b = sclk_b; pm_b = mosi_b; pd_b = dc_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int          k, first_rise, second_rise, cs_hi, nbad;
    logic        ps;
    logic [7:0]  eb;
    logic        ed;
    logic [7:0]  exp_b[7];
    logic        exp_bd[7];

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst cs_n", cs_a, 1); chk("rst sclk", sclk_a, 0); chk("rst mosi", mosi_a, 0);
        chk("rst dc", dc_a, 0);   chk("rst rd", rd_a, 0);     chk("rst addr", addr_a, 0);
        chk("rst busy", busy_a, 0); chk("rst done", done_a, 0);
        @(negedge clk) rst = 1'b0;

        // small instance: CLK_DIV=1, PAGES=1, COLS=4
        @(posedge clk); #2; start_b = 1'b1;
        @(posedge clk); #2; start_b = 1'b0;
        chk("b busy after start", busy_b, 1); chk("b cs_n after start", cs_b, 0);
        k = 0;
        while (!done_b && k < 400) begin @(posedge clk); #2; k++; end
        chk("b done edge", k, 124);
        exp_b  = '{8'hB0, 8'h10, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        exp_bd = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        chk("b byte count", qb_byte.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < qb_byte.size()) begin
                chk($sformatf("b byte%0d", i), qb_byte[i], exp_b[i]);
                chk($sformatf("b dc%0d", i), qb_dc[i], exp_bd[i]);
            end
        end
        chk("b rd count", rd_addr_b.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < rd_addr_b.size()) chk($sformatf("b rd addr%0d", i), rd_addr_b[i], i);
        chk("b mosi/dc stable while sclk high", viol_b, 0);
        @(posedge clk); #2;
        chk("b done single pulse", done_b, 0);

        // default instance: full frame with a start re-pulse mid page 5
        rd_cnt_a = 0;
        start_a = 1'b1;
        @(posedge clk); #2; start_a = 1'b0;
        chk("a busy after start", busy_a, 1); chk("a cs_n after start", cs_a, 0);
        k = 0; first_rise = -1; second_rise = -1; cs_hi = 0; ps = 1'b0;
        while (!done_a && k < 40000) begin
            @(posedge clk); #2; k++;
            if (sclk_a && !ps) begin
                if (first_rise < 0) first_rise = k;
                else if (second_rise < 0) second_rise = k;
            end
            ps = sclk_a;
            start_a = (k == 24000);
            if (cs_a && !done_a) cs_hi++;
        end
        start_a = 1'b0;
        chk("a first sclk rise edge", first_rise, 3);
        chk("a second sclk rise edge", second_rise, 7);
        chk("a done edge", k, 35609);
        chk("a cs_n low through frame", cs_hi, 0);
        chk("a rd pulses", rd_cnt_a, 1024);
        chk("a byte count", qa_byte.size(), 1048);
        nbad = 0;
        for (int p = 0; p < 8; p++) begin
            for (int j = 0; j < 131; j++) begin
                if (j == 0)      begin eb = 8'hB0 | 8'(p); ed = 1'b0; end
                else if (j == 1) begin eb = 8'h10; ed = 1'b0; end
                else if (j == 2) begin eb = 8'h00; ed = 1'b0; end
                else             begin eb = ram_byte(10'(p * 128 + j - 3)); ed = 1'b1; end
                if (p * 131 + j >= qa_byte.size()) nbad++;
                else if (qa_byte[p*131+j] !== eb || qa_dc[p*131+j] !== ed) nbad++;
            end
        end
        chk("a frame byte/dc mismatches", nbad, 0);

        // back-to-back: start in the idle cycle that carries done
        chk("a cs_n high at done", cs_a, 1);
        qa_byte.delete(); qa_dc.delete();
        start_a = 1'b1;
        @(posedge clk); #2; start_a = 1'b0;
        chk("a done single pulse", done_a, 0);
        chk("a cs_n low again after 1 clk", cs_a, 0);
        chk("a busy second frame", busy_a, 1);

        // run second frame to page 3 col 50, then reset in the middle of that byte
        k = 0;
        while (!(rd_a && addr_a == 10'd434) && k < 20000) begin @(posedge clk); #2; k++; end
        chk("a reached p3 c50 fetch", rd_a, 1);
        repeat (6) @(posedge clk);
        #2;
        chk("a mid-shift busy", busy_a, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid rst cs_n", cs_a, 1); chk("mid rst sclk", sclk_a, 0);
        chk("mid rst rd", rd_a, 0);   chk("mid rst busy", busy_a, 0);
        chk("mid rst addr", addr_a, 0);
        chk("bytes before abort", qa_byte.size(), 446);
        @(negedge clk) rst = 1'b0;
        qa_byte.delete(); qa_dc.delete();
        @(posedge clk); #2; start_a = 1'b1;
        @(posedge clk); #2; start_a = 1'b0;
        k = 0;
        while (qa_byte.size() == 0 && k < 100) begin @(posedge clk); #2; k++; end
        chk("restart byte seen", qa_byte.size() > 0, 1);
        if (qa_byte.size() > 0) begin
            chk("restart first byte", qa_byte[0], 8'hB0);
            chk("restart first dc", qa_dc[0], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
